// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the execute-stage ALU and the ALU-control decoder.
//   - ALU_WIDTH   : default datapath width
//   - alu_ctrl_t  : 3-bit ALUControl operation codes
//   - alu_state_t : sequencing states of alu_seq
//   - is_shift_op : true for the two serial-shift operations
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_PASS = 3'b101,
      ALU_SLL  = 3'b110,
      ALU_SRL  = 3'b111
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } alu_state_t;

   function automatic logic is_shift_op(alu_ctrl_t op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_seq_serial_shifter.sv
// serial_shifter
//   One-bit-per-cycle logical shifter used by alu_seq for slli/srli.
//   Ports:
//   - clk, rst_n  : clock, asynchronous active-low reset
//   - load        : capture load_value/load_count/load_left
//   - step        : shift acc by one and decrement the remaining count
//   - load_value  : operand to be shifted
//   - load_count  : shift amount (must be >= 1 when loaded)
//   - load_left   : 1 = shift left, 0 = shift right
//   - value       : acc advanced by one more step (the value the next step produces)
//   - done        : the next step is the final one
module serial_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   load_value,
   input  logic [SHAMT_W-1:0] load_count,
   input  logic               load_left,
   output logic [WIDTH-1:0]   value,
   output logic               done
);

   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] cnt;
   logic               left;

   // Exposing the one-step-ahead value lets the owner capture the final
   // result on the same edge that retires the last step, saving a cycle.
   assign value = left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
   assign done  = (cnt == SHAMT_W'(1));

   // Accumulator, remaining count and latched direction. Load wins over step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         cnt  <= '0;
         left <= 1'b0;
      end else if (load) begin
         acc  <= load_value;
         cnt  <= load_count;
         left <= load_left;
      end else if (step) begin
         acc  <= value;
         cnt  <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Sequential execute-stage ALU. Logic/arithmetic ops finish in one edge;
//   shifts run on a serial shifter (shamt+1 edges). Valid/ready on both sides.
//   Ports:
//   - clk, rst_n            : clock, asynchronous active-low reset
//   - in_valid / in_ready   : request handshake
//   - ALUControl, SrcA, SrcB: operation and operands (shamt = SrcB[SHAMT_W-1:0])
//   - out_valid / out_ready : result handshake
//   - ALUResult, Zero       : registered result and its zero flag
//   - busy                  : a serial shift is in flight
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             busy
);

   alu_state_t         state;
   alu_state_t         state_next;
   alu_ctrl_t          op;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;
   logic               start_shift;
   logic [WIDTH-1:0]   quick_result;
   logic [WIDTH-1:0]   shift_value;
   logic               shift_done;

   assign op          = alu_ctrl_t'(ALUControl);
   assign shamt       = SrcB[SHAMT_W-1:0];
   assign accept      = in_valid && in_ready;
   assign start_shift = accept && is_shift_op(op) && (shamt != '0);

   // DONE accepts only when its own result is being taken on the same edge,
   // which is what gives back-to-back throughput.
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);

   // Single-cycle result. A shift only lands here with shamt == 0, where the
   // answer is SrcA unchanged.
   always_comb begin
      quick_result = '0;
      case (op)
         ALU_ADD:  quick_result = SrcA + SrcB;
         ALU_SUB:  quick_result = SrcA - SrcB;
         ALU_AND:  quick_result = SrcA & SrcB;
         ALU_OR:   quick_result = SrcA | SrcB;
         ALU_XOR:  quick_result = SrcA ^ SrcB;
         ALU_PASS: quick_result = SrcB;
         default:  quick_result = SrcA;
      endcase
   end

   serial_shifter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (start_shift),
      .step       (state == SHIFT),
      .load_value (SrcA),
      .load_count (shamt),
      .load_left  (op == ALU_SLL),
      .value      (shift_value),
      .done       (shift_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. IDLE and DONE share the accept rules.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = start_shift ? SHIFT : DONE;
         end
         SHIFT: begin
            if (shift_done) state_next = DONE;
         end
         DONE: begin
            if (accept)         state_next = start_shift ? SHIFT : DONE;
            else if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Result and Zero only load on a completing edge, so they stay put while
   // DONE is waiting on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALUResult <= '0;
         Zero      <= 1'b1;
      end else if (accept && !start_shift) begin
         ALUResult <= quick_result;
         Zero      <= (quick_result == '0);
      end else if ((state == SHIFT) && shift_done) begin
         ALUResult <= shift_value;
         Zero      <= (shift_value == '0);
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Scoreboard bench for alu_seq: the driver pushes the expected result and
//   latency of every accepted op; a monitor pops and compares on each output
//   handshake. Directed cases first, then randomized ops with random backpressure.
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ALUControl;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      int          accept_edge;
      int          latency;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cycle    = 0;
   logic        rand_bp  = 1'b0;

   alu_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so accept and result edges can be compared.
   initial forever begin
      @(posedge clk);
      cycle++;
   end

   // Reference model: the ALU's rules written as plain arithmetic.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return b;
         3'd6:    return a << sh;
         default: return a >> sh;
      endcase
   endfunction

   function automatic int model_latency(input logic [2:0] op, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      if (op >= 3'd6 && sh != 0) return sh + 1;
      return 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic failTimeout(input string name);
      n_checks++;
      $display("[TB] FAIL %s: timed out waiting for the DUT", name);
   endtask

   // Present one request and hold it until accepted. Entered just after a
   // rising edge; returns just after the accept edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int   waited;
      exp_t e;
      waited     = 0;
      in_valid   = 1'b1;
      ALUControl = op;
      SrcA       = a;
      SrcB       = b;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) begin
            failTimeout("accept");
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
      e.res         = model(op, a, b);
      e.accept_edge = cycle + 1;
      e.latency     = model_latency(op, b);
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      ALUControl = 3'($urandom);
      SrcA       = $urandom;
      SrcB       = $urandom;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Monitor: record when each result first appears, check it stays stable
   // under backpressure, and compare against the scoreboard on handshake.
   initial begin
      logic        seen;
      logic [31:0] held;
      int          first_edge;
      exp_t        e;
      seen = 1'b0;
      held = '0;
      first_edge = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (out_valid) begin
            if (!seen) begin
               seen       = 1'b1;
               held       = ALUResult;
               first_edge = cycle;
            end else begin
               checkOutput("held_result", ALUResult, held);
            end
            if (out_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  $display("[TB] FAIL unexpected_result: got %h, expected no result", ALUResult);
               end else begin
                  e = sb.pop_front();
                  checkOutput("result", ALUResult, e.res);
                  checkOutput("zero", 32'(Zero), 32'(e.res == 32'd0));
                  checkOutput("latency", 32'(first_edge - e.accept_edge + 1), 32'(e.latency));
               end
               seen = 1'b0;
            end
         end else if (seen) begin
            n_checks++;
            $display("[TB] FAIL valid_dropped: got out_valid 0, expected 1");
            seen = 1'b0;
         end
      end
   end

   task automatic drain();
      int waited;
      waited = 0;
      while (sb.size() != 0) begin
         @(posedge clk);
         waited++;
         if (waited > 500) begin
            failTimeout("drain");
            sb.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] b;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      ALUControl = 3'd0;
      SrcA       = '0;
      SrcB       = '0;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_result", ALUResult, 32'd0);
      checkOutput("rst_zero", 32'(Zero), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Add / sub with zero flag.
      applyStimulus(3'd0, 32'd5, 32'd7);
      applyStimulus(3'd1, 32'd5, 32'd5);
      drain();

      // Shifts including maximum latency and shamt 0, then pass-B.
      applyStimulus(3'd6, 32'd1, 32'd4);
      @(negedge clk);
      checkOutput("busy_in_shift", 32'(busy), 32'd1);
      drain();
      applyStimulus(3'd7, 32'h8000_0000, 32'd31);
      drain();
      applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd0);
      applyStimulus(3'd5, $urandom, 32'h1234_5000);
      drain();

      // Backpressure: result held, no new request accepted.
      out_ready = 1'b0;
      applyStimulus(3'd4, 32'hFF, 32'h0F);
      repeat (10) begin
         @(negedge clk);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         checkOutput("bp_result", ALUResult, 32'hF0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(3'd3, 32'hA0, 32'h05);
      drain();

      // Streaming non-shift ops.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(3'($urandom_range(0, 5)), $urandom, $urandom);
      end
      drain();

      // Reset during a 20-bit shift.
      applyStimulus(3'd6, $urandom, 32'd20);
      repeat (2) @(posedge clk);
      #3;
      checkOutput("busy_before_abort", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_result", ALUResult, 32'd0);
      checkOutput("abort_zero", 32'(Zero), 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(3'd0, 32'd100, 32'd23);
      drain();

      // Random ops with random backpressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom);
         b  = $urandom;
         applyStimulus(op, $urandom, b);
      end
      rand_bp   = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential execute-stage ALU for the reduced RISC-V pipeline, consuming the 3-bit ALUControl code produced by the ALU-control decoder. Logic and arithmetic ops complete in one cycle; `slli`/`srli` run on a serial 1-bit-per-cycle shifter to save area. A valid/ready handshake on each side lets the hazard unit stall the pipeline while a shift is in flight.

## Interface

Parameters:
- WIDTH, 32, datapath width.
- SHAMT_W, 5, shift-amount width, equal to $clog2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- ALUControl  in  3  operation code.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B, or immediate; shift amount is SrcB[SHAMT_W-1:0].
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  (ALUResult == 0), registered with the result.
- busy  out  1  high in SHIFT state; drives the pipeline stall.

## Operation

- ALUControl encodings:
  - 000: A+B.
  - 001: A−B.
  - 010: A&B.
  - 011: A|B.
  - 100: A^B.
  - 101: pass B (lui).
  - 110: A<<shamt (logical).
  - 111: A>>shamt (logical).
- Add and subtract are modulo 2^WIDTH. There is no carry or overflow output.
- Accept condition: in_valid && in_ready. Inputs are sampled only on an accept edge and may change freely afterwards.
- States:
  - IDLE: in_ready=1. On accept:
    - Non-shift op, or shift with shamt==0: register the result → DONE.
    - Shift with shamt≥1: load acc=SrcA, cnt=shamt, latch direction → SHIFT.
  - SHIFT: in_ready=0, busy=1. Each edge shifts acc by 1 in the latched direction, zero-filled, and decrements cnt.
    - The edge where cnt goes 1→0 writes the shifted value to ALUResult → DONE.
  - DONE: out_valid=1. ALUResult and Zero are held stable while out_ready=0.
    - out_ready=1 with no new accept → IDLE.
    - in_ready = out_ready in DONE, so the result is consumed and a new request accepted on the same edge. The new op then follows the IDLE accept rules, giving back-to-back throughput.
- Reset (async assert, any state, including mid-shift):
  - state=IDLE, out_valid=0, ALUResult=0, Zero=1, busy=0, acc=0, cnt=0.
  - The in-flight op is discarded.
  - in_ready=1 from the first cycle after rst_n deasserts.

## Timing

- Latency is counted in clock edges from the accept edge, inclusive, to the edge that raises out_valid:
  - Non-shift op, or shamt==0: 1.
  - Shift with shamt=n≥1: n+1.
  - Maximum: WIDTH.
- Throughput:
  - Non-shift ops: 1 per cycle when out_ready is held high.
  - Shifts: one result per n+1 cycles.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs, except in_ready depending on out_ready in DONE.
- out_valid must not drop before the out_ready handshake.
- ALUResult and Zero must not change while out_valid=1 && out_ready=0.

## Structure

- Shared package `alu_pkg`:
  - `alu_ctrl_t` enum with the eight codes above, also used by the ALU-control decoder.
  - `alu_state_t` enum {IDLE, SHIFT, DONE}.
  - Localparam for the default WIDTH.
- One sub-module, `serial_shifter`: the acc/cnt registers with load, step and direction inputs, and done and value outputs.
- Top level `alu_seq`: FSM, combinational single-cycle ops, result/Zero registers, handshake logic.

## Test plan

- Reset release, then add with A=5, B=7 → out_valid one edge after accept; ALUResult=12, Zero=0. Then sub with A=5, B=5 → ALUResult=0, Zero=1.
- slli with A=1, B=4 → busy high for 4 cycles; out_valid on edge 5; ALUResult=16. srli with A=0x8000_0000, B=31 → ALUResult=1 at edge 32, the maximum latency.
- Shift with shamt=0 (A=0xDEAD_BEEF, slli) → 1-cycle latency; ALUResult=0xDEAD_BEEF. Pass-B with B=0x1234_5000 → ALUResult=0x1234_5000.
- Backpressure: hold out_ready=0 for 10 cycles after an xor of 0xFF and 0x0F → ALUResult=0xF0 stays stable, in_ready=0. Then assert out_ready with in_valid high → the next op is accepted on the same edge.
- Streaming: 8 consecutive non-shift ops with out_ready=1 → one result per cycle, in order, with no bubbles.
- Assert rst_n low at cycle 3 of a 20-bit shift → outputs go to reset values immediately. After release, a new add completes correctly with no residue from the aborted shift.
